// File: rtl/x25519_byte_frontend.sv
// x25519_byte_frontend: byte-serial load/unload wrapper around the X25519
// scalar_multiplication core.
//   - Takes 64 input bytes: a 32-byte scalar, then a 32-byte u-coordinate,
//     both least significant byte first.
//   - Clamps the scalar, then masks and reduces u mod p = 2^255-19.
//   - Runs the core by releasing its reset.
//   - Returns x_q as 32 bytes, least significant byte first.
// Optional build macro: X25519_CLAMP_EN. When it is defined, the full X25519
// scalar clamp is applied. When it is undefined, the raw scalar is passed on
// with only bit 255 cleared.
module x25519_byte_frontend #(
  parameter logic [31:0] TIMEOUT = 32'd4000000  // RUN cycle limit, 0 = none
) (
  input  logic         clk,
  input  logic         rst,        // asynchronous, active low
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   out_data,
  output logic         out_last,
  output logic         err,
  output logic         core_rst,
  output logic [254:0] core_k,
  output logic [254:0] core_x_p,
  input  logic [254:0] core_x_q,
  input  logic         core_done
);

  localparam logic [1:0] S_LOAD = 2'd0;
  localparam logic [1:0] S_PREP = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_SEND = 2'd3;

  // Field prime p = 2^255 - 19.
  localparam logic [254:0] P = {{247{1'b1}}, 8'hED};

  logic [1:0]   state;
  logic [1:0]   state_nx;
  logic [5:0]   idx;
  logic [4:0]   oidx;
  logic [511:0] in_buf;
  logic [255:0] out_buf;
  logic [31:0]  run_cnt;
  logic         core_rst_q;

  logic         in_fire;
  logic         out_fire;
  logic         run_done;
  logic         run_abort;
  logic [254:0] u_val;
  logic [254:0] u_red;
  logic [254:0] k_clamp;

  // Handshakes and RUN exit conditions. A done in the first RUN cycle is
  // ignored, and done takes priority over the timeout.
  always_comb begin
    in_fire   = in_valid && in_ready;
    out_fire  = out_valid && out_ready;
    run_done  = (state == S_RUN) && (run_cnt != 32'd0) && core_done;
    run_abort = (state == S_RUN) && !run_done && (TIMEOUT != 32'd0) &&
                (run_cnt == TIMEOUT - 32'd1);
  end

  // Next-state logic for LOAD -> PREP -> RUN -> SEND -> LOAD.
  // NOTE: assigning a default first means no path leaves state_nx unassigned,
  // so no latch is inferred.
  always_comb begin
    state_nx = state;
    case (state)
      S_LOAD: if (in_fire && idx == 6'd63) state_nx = S_PREP;
      S_PREP: state_nx = S_RUN;
      S_RUN:  if (run_done || run_abort) state_nx = S_SEND;
      S_SEND: if (out_fire && oidx == 5'd31) state_nx = S_LOAD;
      default: state_nx = S_LOAD;
    endcase
  end

  // Operand preparation: mask bit 255 of u, do one conditional subtract of p,
  // and clamp the scalar.
  always_comb begin
    u_val = in_buf[510:256];
    u_red = (u_val >= P) ? (u_val - P) : u_val;
`ifdef X25519_CLAMP_EN
    k_clamp = {1'b1, in_buf[253:3], 3'b000};
`else
    k_clamp = in_buf[254:0];
`endif
  end

  // Control registers. The handshake flags are registered from the next state.
  // NOTE: sequential state uses non-blocking assignments, so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_LOAD;
      idx        <= 6'd0;
      oidx       <= 5'd0;
      run_cnt    <= 32'd0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      core_rst_q <= 1'b1;
      err        <= 1'b0;
    end else begin
      state      <= state_nx;
      in_ready   <= (state_nx == S_LOAD);
      out_valid  <= (state_nx == S_SEND);
      core_rst_q <= (state_nx != S_RUN);
      if (in_fire)  idx  <= idx + 6'd1;
      if (out_fire) oidx <= oidx + 5'd1;
      if (state == S_RUN)
        run_cnt <= (run_cnt != 32'hFFFF_FFFF) ? run_cnt + 32'd1 : run_cnt;
      else
        run_cnt <= 32'd0;
      if (in_fire)        err <= 1'b0;
      else if (run_abort) err <= 1'b1;
    end
  end

  // Core operands are loaded in PREP and held there until the next PREP.
  // The output buffer is a byte shift register that advances on each handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_k   <= '0;
      core_x_p <= '0;
      out_buf  <= '0;
    end else begin
      if (state == S_PREP) begin
        core_k   <= k_clamp;
        core_x_p <= u_red;
      end
      if (run_done)       out_buf <= {1'b0, core_x_q};
      else if (run_abort) out_buf <= '0;
      else if (out_fire)  out_buf <= {8'h00, out_buf[255:8]};
    end
  end

  // Input byte shift buffer. After 64 accepts, byte i sits at bits [8i+7:8i].
  // NOTE: this data buffer has no reset. idx and the FSM decide when it is
  // valid, and a full 64-byte load overwrites every bit.
  always_ff @(posedge clk) begin
    if (in_fire) in_buf <= {in_data, in_buf[511:8]};
  end

  assign out_data = out_buf[7:0];
  assign out_last = out_valid && (oidx == 5'd31);
  // The core stays held in reset while rst is asserted, without waiting for a clock.
  assign core_rst = core_rst_q | ~rst;

endmodule

// File: tb/tb_x25519_byte_frontend.sv
// tb_x25519_byte_frontend: directed, table-driven bench for
// x25519_byte_frontend. A small behavioural core model produces x_q as a
// fixed function of core_k / core_x_p.
module tb_x25519_byte_frontend;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_data;
  logic         out_last;
  logic         err;
  logic         core_rst;
  logic [254:0] core_k;
  logic [254:0] core_x_p;
  logic [254:0] core_x_q;
  logic         core_done;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [254:0] SALT = {7'h2b, {31{8'hC6}}};

  x25519_byte_frontend #(.TIMEOUT(32'd100)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .err(err),
    .core_rst(core_rst), .core_k(core_k), .core_x_p(core_x_p),
    .core_x_q(core_x_q), .core_done(core_done)
  );

  always #5 clk = ~clk;

  // Core model. done_mode 0: done is never asserted. done_mode 1: done from
  // RUN cycle done_delay onward. done_mode 2: a done pulse in the first RUN
  // cycle only.
  int done_mode  = 0;
  int done_delay = 0;
  int run_cyc    = 0;
  always @(posedge clk) begin
    if (core_rst) run_cyc <= 0;
    else          run_cyc <= run_cyc + 1;
  end
  assign core_done = !core_rst &&
                     ((done_mode == 1 && run_cyc >= done_delay) ||
                      (done_mode == 2 && run_cyc == 0));
  assign core_x_q  = core_k ^ {core_x_p[253:0], 1'b0} ^ SALT;

  typedef struct {
    logic [255:0] s;
    logic [255:0] u;
    logic [255:0] k;     // expected core_k, zero-extended
    logic [255:0] xp;    // expected core_x_p, zero-extended
    int           delay;
    int           lat;   // expected negedges from the first RUN cycle to out_valid
    bit           gaps;
    bit           toggle;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [255:0] got,
                       input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, got, exp);
    end
  endtask

  function automatic logic [255:0] exp_xq(input logic [255:0] k,
                                          input logic [255:0] xp);
    logic [254:0] r;
    r = k[254:0] ^ {xp[253:0], 1'b0} ^ SALT;
    return {1'b0, r};
  endfunction

  // Load 64 bytes. Call at a negedge; returns at the negedge after the last accept.
  task automatic load(input logic [255:0] s, input logic [255:0] u, input bit gaps);
    logic [511:0] all;
    int w;
    all = {u, s};
    for (int i = 0; i < 64; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = all[i*8 +: 8];
      w = 0;
      while (!in_ready && w < 200) begin
        @(negedge clk);
        w++;
      end
      if (!in_ready) begin
        check("in_ready_wait", 256'(in_ready), 256'd1);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 1000) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Collect 32 output bytes and compare each one with exp.
  task automatic recv(input logic [255:0] exp, input bit toggle, input string tag);
    int got;
    int cyc;
    got = 0;
    cyc = 0;
    while (got < 32 && cyc < 2000) begin
      out_ready = toggle ? ((cyc % 2) == 1) : 1'b1;
      if (out_valid) begin
        check($sformatf("%s_byte%0d", tag, got), 256'(out_data), 256'(exp[got*8 +: 8]));
        check($sformatf("%s_last%0d", tag, got), 256'(out_last), 256'(got == 31));
        if (out_ready) got++;
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    if (got < 32) check($sformatf("%s_recv_count", tag), 256'(got), 256'd32);
    check($sformatf("%s_post_valid", tag), 256'(out_valid), 256'd0);
    check($sformatf("%s_post_ready", tag), 256'(in_ready), 256'd1);
  endtask

  task automatic do_txn(input vec_t v, input string tag);
    int n;
    done_mode  = 1;
    done_delay = v.delay;
    load(v.s, v.u, v.gaps);
    check({tag, "_prep_core_rst"}, 256'(core_rst), 256'd1);
    check({tag, "_prep_in_ready"}, 256'(in_ready), 256'd0);
    @(negedge clk);
    check({tag, "_run_core_rst"}, 256'(core_rst), 256'd0);
    check({tag, "_core_k"}, 256'(core_k), v.k);
    check({tag, "_core_x_p"}, 256'(core_x_p), v.xp);
    check({tag, "_run_err"}, 256'(err), 256'd0);
    wait_valid(n);
    check({tag, "_latency"}, 256'(n), 256'(v.lat));
    recv(exp_xq(v.k, v.xp), v.toggle, tag);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_core_rst"},  256'(core_rst),  256'd1);
    check({tag, "_in_ready"},  256'(in_ready),  256'd0);
    check({tag, "_out_valid"}, 256'(out_valid), 256'd0);
    check({tag, "_out_last"},  256'(out_last),  256'd0);
    check({tag, "_out_data"},  256'(out_data),  256'd0);
    check({tag, "_err"},       256'(err),       256'd0);
    check({tag, "_core_k"},    256'(core_k),    256'd0);
    check({tag, "_core_x_p"},  256'(core_x_p),  256'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [255:0] p_w;
    logic [255:0] b254;
    logic [255:0] b255;
    int n;

    p_w  = (256'd1 << 255) - 256'd19;
    b254 = 256'd1 << 254;
    b255 = 256'd1 << 255;

    // s = 0, u = 9.
    vecs[0].s = '0;             vecs[0].u = 256'd9;
    vecs[0].xp = 256'd9;        vecs[0].delay = 1; vecs[0].lat = 2;
    vecs[0].gaps = 1'b0;        vecs[0].toggle = 1'b0;
    // All-ones scalar and u: masked u = 2^255-1 reduces to 18.
    vecs[1].s = {256{1'b1}};    vecs[1].u = {256{1'b1}};
    vecs[1].xp = 256'd18;       vecs[1].delay = 3; vecs[1].lat = 4;
    vecs[1].gaps = 1'b0;        vecs[1].toggle = 1'b0;
    // u = p reduces to 0. done is asserted from the first RUN cycle (captured in the second).
    vecs[2].s = b255 + 256'd7;  vecs[2].u = p_w;
    vecs[2].xp = 256'd0;        vecs[2].delay = 0; vecs[2].lat = 2;
    vecs[2].gaps = 1'b0;        vecs[2].toggle = 1'b0;
    // u = p-1 passes through unchanged. Input gaps and a toggling out_ready.
    vecs[3].s = {32{8'h55}};    vecs[3].u = p_w - 256'd1;
    vecs[3].xp = p_w - 256'd1;  vecs[3].delay = 5; vecs[3].lat = 6;
    vecs[3].gaps = 1'b1;        vecs[3].toggle = 1'b1;
    // u = p+1 with bit 255 set reduces to 1.
    vecs[4].s = 256'd1;         vecs[4].u = b255 + p_w + 256'd1;
    vecs[4].xp = 256'd1;        vecs[4].delay = 2; vecs[4].lat = 3;
    vecs[4].gaps = 1'b1;        vecs[4].toggle = 1'b1;
    // Bit 255 set on an otherwise small u: the mask alone gives 5.
    vecs[5].s = (256'd3 << 254) + 256'd15; vecs[5].u = b255 + 256'd5;
    vecs[5].xp = 256'd5;        vecs[5].delay = 1; vecs[5].lat = 2;
    vecs[5].gaps = 1'b0;        vecs[5].toggle = 1'b1;
`ifdef X25519_CLAMP_EN
    vecs[0].k = b254;
    vecs[1].k = b255 - 256'd8;
    vecs[2].k = b254;
    vecs[3].k = {32{8'h55}} & ~256'd7;
    vecs[4].k = b254;
    vecs[5].k = b254 + 256'd8;
`else
    vecs[0].k = 256'd0;
    vecs[1].k = b255 - 256'd1;
    vecs[2].k = 256'd7;
    vecs[3].k = {32{8'h55}};
    vecs[4].k = 256'd1;
    vecs[5].k = b254 + 256'd15;
`endif

    rst = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    rst = 1'b1;
    #1 check("in_ready_before_edge", 256'(in_ready), 256'd0);
    @(posedge clk);
    #1 check("in_ready_after_edge", 256'(in_ready), 256'd1);
    @(negedge clk);

    for (int i = 0; i < 6; i++) do_txn(vecs[i], $sformatf("v%0d", i));

    // Timeout: a single done pulse in the first RUN cycle must be ignored.
    done_mode = 2;
    load(vecs[1].s, vecs[1].u, 1'b0);
    @(negedge clk);
    check("tmo_run_core_rst", 256'(core_rst), 256'd0);
    wait_valid(n);
    check("tmo_cycles", 256'(n), 256'd100);
    check("tmo_err_set", 256'(err), 256'd1);
    recv('0, 1'b0, "tmo");
    check("tmo_err_held", 256'(err), 256'd1);
    do_txn(vecs[0], "after_tmo");   // its RUN err check shows the clear

    // Reset pulse while in RUN.
    done_mode = 1; done_delay = 1000;
    load(vecs[3].s, vecs[3].u, 1'b0);
    @(negedge clk);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1 check_reset_vals("rst_run");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_run_ready_back", 256'(in_ready), 256'd1);

    // Reset pulse in the middle of SEND.
    done_mode = 1; done_delay = 2;
    load(vecs[4].s, vecs[4].u, 1'b0);
    wait_valid(n);
    check("rst_send_reached", 256'(out_valid), 256'd1);
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    out_ready = 1'b0;
    rst = 1'b0;
    #1 check_reset_vals("rst_send");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    do_txn(vecs[1], "after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/x25519_byte_frontend.md
# x25519_byte_frontend

Byte-serial front/back end for the 255-bit X25519 `scalar_multiplication` core. It accepts a 32-byte little-endian scalar and a 32-byte little-endian u-coordinate over a valid/ready byte stream. It clamps the scalar, masks and reduces the u-coordinate mod p = 2^255−19, and launches the core by releasing the core's reset. It then captures `x_q` on `done` and streams it back out as 32 little-endian bytes.

## Interface
- `TIMEOUT`, default 32'd4000000: RUN-state cycle limit before abort; 0 disables the timeout.
- `clk` input 1: clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `in_valid` input 1: input byte valid.
- `in_ready` output 1: block accepts a byte this cycle.
- `in_data` input 8: input byte. Bytes 0–31 are the scalar (LSB first); bytes 32–63 are u (LSB first).
- `out_valid` output 1: output byte valid.
- `out_ready` input 1: downstream accepts the byte.
- `out_data` output 8: result byte, `x_q` little-endian.
- `out_last` output 1: high with byte 31.
- `err` output 1: set by a timeout abort.
- `core_rst` output 1: active-high reset driven to the core; low only in RUN.
- `core_k` output 255: scalar to the core.
- `core_x_p` output 255: base u-coordinate to the core.
- `core_x_q` input 255: core result.
- `core_done` input 1: core completion.

## Operation
- States: LOAD → PREP → RUN → SEND → LOAD.
- **LOAD**
  - `in_ready`=1.
  - Each `in_valid && in_ready` stores `in_data` at byte index idx (0–63) of a 512-bit shift buffer, then increments idx.
  - The accept at idx=63 moves to PREP.
  - Any accepted byte clears `err`.
- **PREP** (1 cycle)
  - Scalar s = bytes 0–31; u = bytes 32–63 with bit 255 cleared.
  - `core_k` ← clamp(s)[254:0].
  - `core_x_p` ← (u ≥ p) ? u − p : u. Use a single 255-bit compare/subtract; only u ∈ [p, 2^255−1] is reduced.
  - Go to RUN.
- **RUN**
  - `core_rst`=0.
  - `core_done` is ignored in the first RUN cycle.
  - On the first later cycle with `core_done`=1: latch `core_x_q` into the output buffer and go to SEND.
  - A cycle counter starts at 0 on RUN entry. If TIMEOUT≠0 and the counter reaches TIMEOUT−1 without done: load zero into the output buffer, set `err`=1, go to SEND.
- **SEND**
  - `out_valid`=1.
  - `out_data` = buffer byte oidx.
  - Each `out_valid && out_ready` increments oidx.
  - `out_last`=1 when oidx=31; the handshake at oidx=31 returns to LOAD with idx=0.
- `core_rst`=1 in every state except RUN. `core_k`/`core_x_p` hold their values from PREP until the next PREP.

## Timing
- Reset values (asserted asynchronously):
  - state=LOAD, idx=oidx=0.
  - `in_ready`=0, `out_valid`=0, `out_last`=0, `out_data`=0, `err`=0.
  - `core_rst`=1, `core_k`=0, `core_x_p`=0.
- `in_ready` is registered: it rises on the first clock edge after `rst` deasserts. It is 0 from the edge entering PREP until the edge returning to LOAD.
- `core_rst` falls on the edge entering RUN and rises on the edge leaving RUN.
- Latency:
  - 64th byte accept → `core_rst` low: 2 edges.
  - `core_done` → `out_valid`: 1 edge.
- `out_data`/`out_last` are stable while `out_valid && !out_ready`. Full throughput is 1 byte/cycle in both directions.
- `core_done` is never sampled outside RUN.
- Reset mid-operation: everything returns to reset values immediately and partial inputs are discarded; the core sees `core_rst`=1 combinationally from `rst`.

## Configuration
- `X25519_CLAMP_EN` defined: clamp(s) clears bits 0, 1, 2 and 255, and sets bit 254.
- `X25519_CLAMP_EN` undefined: clamp(s) = s with bit 255 cleared only. Raw scalars are passed through for ladder testing.

## Test plan
- Scalar all 0x00 and u = {0x09, 31×0x00}; the core model returns a known `x_q` → `core_k`=2^254 (with CLAMP_EN) or 0 (without), `core_x_p`=9. 32 output bytes equal the model `x_q` LSB-first, with `out_last` only on byte 31.
- u = 32×0xFF, scalar 32×0xFF → `core_x_p`=18, `core_k`=2^255−8 (CLAMP_EN).
- u = p exactly (0xED, 30×0xFF, 0x7F) → `core_x_p`=0. u = p−1 → `core_x_p`=p−1 unchanged.
- Random `in_valid` gaps and `out_ready` toggling every cycle → identical byte results; `out_data` held while stalled.
- TIMEOUT=100, `core_done` tied 0 → `err`=1 at RUN cycle 100, then 32 zero bytes. The next accepted input byte clears `err`.
- `rst` pulsed low in RUN and again mid-SEND → `core_rst`=1, `out_valid`=0, `in_ready`=0 during reset. A fresh 64-byte load afterward completes normally.
